mult_pipe_sgn: RTL

Parametrised successor to the team's shift-add pipelined multiplier. Computes an N x M product through M pipeline stages, one partial product per stage. Adds a per-transaction signed/unsigned mode, valid/ready backpressure with full-pipeline stall, a tag passthrough and a configurable output width. Sits in the datapath wherever a multiplier must absorb downstream stalls.

---
 rtl/mult_pipe_sgn.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mult_pipe_sgn.sv
// Pipelined N x M shift-add multiplier with per-op signed/unsigned mode, full-pipe stall,
// tag passthrough and optional output narrowing. Define MULT_SAT_EN to saturate narrowed results.
module mult_pipe_sgn #(
  parameter int unsigned N  = 8,
  parameter int unsigned M  = 4,
  parameter int unsigned TW = 4,
  parameter int unsigned OW = N + M
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic          sgn,
  input  logic [N-1:0]  mult1,
  input  logic [M-1:0]  mult2,
  input  logic [TW-1:0] tag_in,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [OW-1:0] res,
  output logic [TW-1:0] tag_out,
  output logic          ovf
);

  localparam int unsigned W = N + M;
  // Stages 0..M-2 accumulate; the output register is the M-th stage.
  localparam int unsigned S = M - 1;

  logic          vld_q [0:S-1];
  logic          vld_d [0:S-1];
  logic [W-1:0]  acc_q [0:S-1];
  logic [W-1:0]  acc_d [0:S-1];
  logic [W-1:0]  a_q   [0:S-1];
  logic [W-1:0]  a_d   [0:S-1];
  logic [M-1:0]  b_q   [0:S-1];
  logic [M-1:0]  b_d   [0:S-1];
  logic          sgn_q [0:S-1];
  logic          sgn_d [0:S-1];
  logic [TW-1:0] tag_q [0:S-1];
  logic [TW-1:0] tag_d [0:S-1];

  logic          out_vld_q, out_vld_d;
  logic [OW-1:0] res_q, res_d;
  logic [TW-1:0] tag_out_q, tag_out_d;
  logic          ovf_q, ovf_d;

  logic          stall_c;
  logic [W-1:0]  a_ext_c;
  logic [W-1:0]  pp_last_c;
  logic [W-1:0]  prod_c;
  logic [OW-1:0] res_c;
  logic          ovf_c;

  assign stall_c = out_vld_q & ~out_rdy;
  assign in_rdy  = ~stall_c;
  assign a_ext_c = {{M{sgn & mult1[N-1]}}, mult1};

  // Multiplicand travels pre-shifted and the multiplier pre-shifted right, so every
  // stage consumes bit 0 of b against a.
  always_comb begin
    for (int i = 0; i < S; i++) begin
      vld_d[i] = vld_q[i];
      acc_d[i] = acc_q[i];
      a_d[i]   = a_q[i];
      b_d[i]   = b_q[i];
      sgn_d[i] = sgn_q[i];
      tag_d[i] = tag_q[i];
    end
    if (!stall_c) begin
      vld_d[0] = in_vld;
      acc_d[0] = mult2[0] ? a_ext_c : W'(0);
      a_d[0]   = a_ext_c << 1;
      b_d[0]   = mult2 >> 1;
      sgn_d[0] = sgn;
      tag_d[0] = tag_in;
      for (int i = 1; i < S; i++) begin
        vld_d[i] = vld_q[i-1];
        acc_d[i] = acc_q[i-1] + (b_q[i-1][0] ? a_q[i-1] : W'(0));
        a_d[i]   = a_q[i-1] << 1;
        b_d[i]   = b_q[i-1] >> 1;
        sgn_d[i] = sgn_q[i-1];
        tag_d[i] = tag_q[i-1];
      end
    end
  end

  // Final partial product carries negative weight for signed ops.
  always_comb begin
    pp_last_c = b_q[S-1][0] ? a_q[S-1] : W'(0);
    prod_c    = sgn_q[S-1] ? (acc_q[S-1] - pp_last_c) : (acc_q[S-1] + pp_last_c);
  end

  if (OW < W) begin : g_narrow
    logic [W-OW:0] hi_s_c;
    logic          fit_s_c;
    logic          fit_u_c;

    assign hi_s_c  = prod_c[W-1:OW-1];
    assign fit_s_c = (hi_s_c == '0) || (hi_s_c == '1);
    assign fit_u_c = (prod_c[W-1:OW] == '0);
    assign ovf_c   = sgn_q[S-1] ? ~fit_s_c : ~fit_u_c;

`ifdef MULT_SAT_EN
    always_comb begin
      res_c = prod_c[OW-1:0];
      if (ovf_c) begin
        if (sgn_q[S-1]) begin
          res_c = prod_c[W-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        end else begin
          res_c = '1;
        end
      end
    end
`else
    assign res_c = prod_c[OW-1:0];
`endif
  end else begin : g_full
    assign res_c = prod_c;
    assign ovf_c = 1'b0;
  end

  // Result fields only reload when a valid op leaves the last accumulate stage.
  always_comb begin
    out_vld_d = out_vld_q;
    res_d     = res_q;
    tag_out_d = tag_out_q;
    ovf_d     = ovf_q;
    if (!stall_c) begin
      out_vld_d = vld_q[S-1];
      if (vld_q[S-1]) begin
        res_d     = res_c;
        tag_out_d = tag_q[S-1];
        ovf_d     = ovf_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < S; i++) begin
        vld_q[i] <= 1'b0;
        acc_q[i] <= '0;
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        sgn_q[i] <= 1'b0;
        tag_q[i] <= '0;
      end
      out_vld_q <= 1'b0;
      res_q     <= '0;
      tag_out_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      for (int i = 0; i < S; i++) begin
        vld_q[i] <= vld_d[i];
        acc_q[i] <= acc_d[i];
        a_q[i]   <= a_d[i];
        b_q[i]   <= b_d[i];
        sgn_q[i] <= sgn_d[i];
        tag_q[i] <= tag_d[i];
      end
      out_vld_q <= out_vld_d;
      res_q     <= res_d;
      tag_out_q <= tag_out_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_vld = out_vld_q;
  assign res     = res_q;
  assign tag_out = tag_out_q;
  assign ovf     = ovf_q;

endmodule
